clk_mgr_a: RTL and testbench



---
 rtl/clk_mgr_a_pkg.sv | 41 ++++
 rtl/clk_mgr_a_if.sv | 18 +
 rtl/clk_mgr_a_gen.sv | 69 ++++++
 rtl/clk_mgr_a.sv | 64 ++++++
 tb/tb_clk_mgr_a.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/clk_mgr_a_pkg.sv
// Shared constants and helpers for the clk_mgr_a behavioural clock manager.
// Holds family names, default frequencies, period arithmetic and parameter checks.
`timescale 1ns/1ps
package clk_mgr_a_pkg;

    localparam logic [63:0] FAM_ARTIX7   = "ARTIX7";
    localparam logic [63:0] FAM_VIRTEX6  = "VIRTEX6";
    localparam logic [63:0] FAM_SPARTAN6 = "SPARTAN6";
    localparam logic [63:0] FAM_ZYNQ7000 = "ZYNQ7000";
    localparam logic [63:0] FAM_VIRTEXUS = "VirtexUS";

    localparam int unsigned DEF_INPUT_CLOCK_FREQ = 50_000_000;
    localparam int unsigned DEF_SYSCLK_FREQ      = 100_000_000;
    localparam int unsigned DEF_CLKOUT1_FREQ     = 100_000_000;
    localparam int unsigned DEF_CLKOUT2_FREQ     = 25_000_000;
    localparam int unsigned DEF_CLKOUT3_FREQ     = 50_000_000;
    localparam int unsigned DEF_CLKOUT4_FREQ     = 250_000_000;
    localparam int unsigned DEF_LOCK_CYCLES      = 16;

    localparam longint unsigned MAX_FREQ = 64'd1_000_000_000;

    function automatic longint unsigned period_ps(input longint unsigned freq);
        return (64'd1_000_000_000_000 + freq / 2) / freq;
    endfunction

    // High phase; an odd leftover picosecond stays in the low phase.
    function automatic longint unsigned half_period_ps(input longint unsigned freq);
        return period_ps(freq) / 2;
    endfunction

    function automatic bit freq_ok(input longint unsigned freq);
        return (freq != 0) && (freq <= MAX_FREQ);
    endfunction

    function automatic bit family_ok(input logic [63:0] fam);
        return (fam == FAM_ARTIX7)   || (fam == FAM_VIRTEX6)  ||
               (fam == FAM_SPARTAN6) || (fam == FAM_ZYNQ7000) ||
               (fam == FAM_VIRTEXUS);
    endfunction

endpackage

// File: rtl/clk_mgr_a_if.sv
// Generated-clock bundle from clk_mgr_a to the system/USB-bridge logic.
`timescale 1ns/1ps
interface clk_mgr_a_if;
    logic OSC_OUT;
    logic SYS_CLK_OUT;
    logic CLKOUT1;
    logic CLKOUT2;
    logic CLKOUT3;
    logic CLKOUT4;
    logic SYS_CLK_LOCKED;

    modport master (
        output OSC_OUT, SYS_CLK_OUT, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4, SYS_CLK_LOCKED
    );
    modport slave (
        input OSC_OUT, SYS_CLK_OUT, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4, SYS_CLK_LOCKED
    );
endinterface

// File: rtl/clk_mgr_a_gen.sv
// One behavioural clock generator: starts high when en rises, 50% duty at FREQ, killed by en/rst_n low.
// CLK_MGR_A_REPORT_EN adds a one-period measurement report after each lock.
`timescale 1ns/1ps
module clk_mgr_a_gen
    import clk_mgr_a_pkg::*;
#(
    parameter int unsigned FREQ = DEF_SYSCLK_FREQ,
    parameter string       NAME = "CLK"
) (
    input  logic rst_n,
    input  logic en,
    output logic clk_o
);
    localparam longint unsigned SAFE_FREQ = (FREQ == 0) ? 64'd1 : 64'(FREQ);
    localparam longint unsigned PER_PS    = period_ps(SAFE_FREQ);
    localparam longint unsigned HI_PS     = half_period_ps(SAFE_FREQ);
    localparam longint unsigned LO_PS     = PER_PS - HI_PS;
    localparam real             HI_NS     = real'(HI_PS) / 1000.0;
    localparam real             LO_NS     = real'(LO_PS) / 1000.0;

    if (!freq_ok(64'(FREQ))) begin : g_bad_freq
        $fatal(1, "clk_mgr_a_gen %s: frequency %0d Hz out of range", NAME, FREQ);
    end

    logic        clk_q = 1'b0;
    int unsigned epoch = 0;

    // Each enable change opens a new epoch; toggle loops from an older epoch
    // wake up, see the mismatch and retire without touching the output.
    always @(en) begin
        epoch = epoch + 1;
        clk_q = en;
        if (en) begin
            fork
                begin : run
                    automatic int unsigned my_epoch = epoch;
                    while (my_epoch == epoch) begin
                        #(HI_NS);
                        if (my_epoch == epoch) clk_q = 1'b0;
                        #(LO_NS);
                        if (my_epoch == epoch) clk_q = 1'b1;
                    end
                end
            join_none
        end
    end

    assign clk_o = clk_q & en & rst_n;

`ifdef CLK_MGR_A_REPORT_EN
    real t_rise;
    real meas_ns;
    real dev_ns;
    always @(posedge en) begin
        t_rise = $realtime;
        @(posedge clk_o);
        if (en) begin
            meas_ns = $realtime - t_rise;
            dev_ns  = meas_ns - 1.0e9 / real'(SAFE_FREQ);
            $display("%m %s %.2f-nsec %.2f-MHz", NAME, meas_ns, 1000.0 / meas_ns);
            if (dev_ns > 0.001 || dev_ns < -0.001)
                $error("%m %s period %.3f ns off target by %.4f ns", NAME, meas_ns, dev_ns);
        end
    end
`else
    // Measurement reporting is compiled out.
`endif

endmodule

// File: rtl/clk_mgr_a.sv
// Behavioural clock manager: counts LOCK_CYCLES OSC_IN edges after reset, then starts five phase-aligned clocks.
// Optional CLK_MGR_A_REPORT_EN enables per-output period reports in the generators.
`timescale 1ns/1ps
module clk_mgr_a
    import clk_mgr_a_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK_FREQ = DEF_INPUT_CLOCK_FREQ,
    parameter int unsigned SYSCLK_FREQ      = DEF_SYSCLK_FREQ,
    parameter int unsigned CLKOUT1_FREQ     = DEF_CLKOUT1_FREQ,
    parameter int unsigned CLKOUT2_FREQ     = DEF_CLKOUT2_FREQ,
    parameter int unsigned CLKOUT3_FREQ     = DEF_CLKOUT3_FREQ,
    parameter int unsigned CLKOUT4_FREQ     = DEF_CLKOUT4_FREQ,
    parameter logic [63:0] FPGA_FAMILY      = FAM_ARTIX7,
    parameter int unsigned LOCK_CYCLES      = DEF_LOCK_CYCLES
) (
    input  logic          OSC_IN,
    input  logic          RST_N,
    clk_mgr_a_if.master   clk_if
);
    localparam logic [1:0] ST_RESET   = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int unsigned LOCK_N = (LOCK_CYCLES == 0) ? 1 : LOCK_CYCLES;
    // Spartan-6 routes CLKOUT1 from the system clock output.
    localparam int unsigned C1_FREQ = (FPGA_FAMILY == FAM_SPARTAN6) ? SYSCLK_FREQ : CLKOUT1_FREQ;

    if (!family_ok(FPGA_FAMILY)) begin : g_bad_family
        $fatal(1, "clk_mgr_a: unknown FPGA_FAMILY %s", FPGA_FAMILY);
    end
    if (!freq_ok(64'(INPUT_CLOCK_FREQ))) begin : g_bad_input
        $fatal(1, "clk_mgr_a: INPUT_CLOCK_FREQ %0d Hz out of range", INPUT_CLOCK_FREQ);
    end

    logic [1:0]  state;
    logic [31:0] edge_cnt;
    logic        locked;

    always_ff @(posedge OSC_IN or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_RESET;
            edge_cnt <= '0;
        end else if (state != ST_LOCKED) begin
            edge_cnt <= edge_cnt + 32'd1;
            state    <= (edge_cnt + 32'd1 == LOCK_N) ? ST_LOCKED : ST_ACQUIRE;
        end
    end

    assign locked                = (state == ST_LOCKED);
    assign clk_if.SYS_CLK_LOCKED = locked;
    assign clk_if.OSC_OUT        = OSC_IN;

    clk_mgr_a_gen #(.FREQ(SYSCLK_FREQ), .NAME("SYS_CLK_OUT")) u_sys (
        .rst_n(RST_N), .en(locked), .clk_o(clk_if.SYS_CLK_OUT));
    clk_mgr_a_gen #(.FREQ(C1_FREQ), .NAME("CLKOUT1")) u_c1 (
        .rst_n(RST_N), .en(locked), .clk_o(clk_if.CLKOUT1));
    clk_mgr_a_gen #(.FREQ(CLKOUT2_FREQ), .NAME("CLKOUT2")) u_c2 (
        .rst_n(RST_N), .en(locked), .clk_o(clk_if.CLKOUT2));
    clk_mgr_a_gen #(.FREQ(CLKOUT3_FREQ), .NAME("CLKOUT3")) u_c3 (
        .rst_n(RST_N), .en(locked), .clk_o(clk_if.CLKOUT3));
    clk_mgr_a_gen #(.FREQ(CLKOUT4_FREQ), .NAME("CLKOUT4")) u_c4 (
        .rst_n(RST_N), .en(locked), .clk_o(clk_if.CLKOUT4));

endmodule

// File: tb/tb_clk_mgr_a.sv
// Scoreboard bench for clk_mgr_a: default build plus a Spartan-6 instance with CLKOUT1_FREQ overridden.
`timescale 1ns/1ps
module tb_clk_mgr_a;
    import clk_mgr_a_pkg::*;

    logic OSC_IN = 1'b0;
    logic RST_N  = 1'b0;

    clk_mgr_a_if dut_if ();
    clk_mgr_a_if s6_if ();

    clk_mgr_a u_dut (
        .OSC_IN (OSC_IN),
        .RST_N  (RST_N),
        .clk_if (dut_if.master)
    );

    clk_mgr_a #(
        .FPGA_FAMILY  (FAM_SPARTAN6),
        .CLKOUT1_FREQ (25_000_000)
    ) u_s6 (
        .OSC_IN (OSC_IN),
        .RST_N  (RST_N),
        .clk_if (s6_if.master)
    );

    // 50 MHz oscillator: rising edges at 10, 30, 50, ... ns
    always #10 OSC_IN = ~OSC_IN;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $realtime);
        end
    endtask

    function automatic longint now_ps();
        return longint'($realtime * 1000.0);
    endfunction

    wire [5:0] gclk  = {s6_if.CLKOUT1, dut_if.CLKOUT4, dut_if.CLKOUT3,
                        dut_if.CLKOUT2, dut_if.CLKOUT1, dut_if.SYS_CLK_OUT};
    wire [5:0] glock = {s6_if.SYS_CLK_LOCKED, {5{dut_if.SYS_CLK_LOCKED}}};

    // Index 5 is the Spartan-6 CLKOUT1, which must follow SYSCLK_FREQ (100 MHz).
    localparam longint EXP_PER [6] = '{10000, 10000, 40000, 20000, 4000, 10000};
    localparam longint EXP_HI  [6] = '{ 5000,  5000, 20000, 10000, 2000,  5000};

    longint lock_q [$];
    longint per_q  [6][$];
    longint hi_q   [6][$];

    task automatic expect_lock(input longint t_ps, input bit with_clocks);
        lock_q.push_back(t_ps);
        if (with_clocks) begin
            for (int i = 0; i < 6; i++) begin
                per_q[i].push_back(EXP_PER[i]);
                hi_q[i].push_back(EXP_HI[i]);
            end
        end
    endtask

    task automatic check_all_low(input string name);
        check(name, longint'({dut_if.SYS_CLK_OUT, dut_if.CLKOUT1, dut_if.CLKOUT2,
                              dut_if.CLKOUT3, dut_if.CLKOUT4, dut_if.SYS_CLK_LOCKED}), 0);
    endtask

    always @(posedge dut_if.SYS_CLK_LOCKED) begin
        if (lock_q.size() == 0)
            check("lock_unexpected_ps", now_ps(), 0);
        else
            check("lock_time_ps", now_ps(), lock_q.pop_front());
    end

    for (genvar i = 0; i < 6; i++) begin : g_mon
        longint t0;
        longint t_fall;
        longint t_rise;
        always @(posedge glock[i]) begin
            if (per_q[i].size() != 0) begin
                t0 = now_ps();
                #0.001;
                check($sformatf("aligned_rise_%0d", i), longint'(gclk[i]), 1);
                @(negedge gclk[i]);
                t_fall = now_ps();
                @(posedge gclk[i]);
                t_rise = now_ps();
                check($sformatf("high_ps_%0d", i), t_fall - t0, hi_q[i].pop_front());
                check($sformatf("period_ps_%0d", i), t_rise - t0, per_q[i].pop_front());
            end
        end
    end

    initial begin
        int left;

        #5;
        check_all_low("reset_values");
        check("osc_out_rst_lo", longint'(dut_if.OSC_OUT), 0);
        #10;
        check("osc_out_rst_hi", longint'(dut_if.OSC_OUT), 1);
        check("s6_osc_out_rst_hi", longint'(s6_if.OSC_OUT), 1);
        check("s6_rst_locked", longint'(s6_if.SYS_CLK_LOCKED), 0);
        #10;
        check("osc_out_rst_lo2", longint'(dut_if.OSC_OUT), 0);

        // Release at 100 ns; 16th rising edge after that is 410 ns.
        #75;
        expect_lock(410_000, 1'b1);
        RST_N = 1'b1;
        #300;
        check_all_low("pre_lock_400ns");

        // 3 ns into the SYS_CLK_OUT high phase that starts at 500 ns.
        #103;
        RST_N = 1'b0;
        #0.001;
        check_all_low("async_drop_503ns");
        check("s6_async_drop", longint'({s6_if.SYS_CLK_OUT, s6_if.CLKOUT1, s6_if.SYS_CLK_LOCKED}), 0);
        #12;
        check_all_low("cancelled_515ns");

        // Re-release at 520 ns; edges from 530, 16th at 830 ns.
        #5;
        expect_lock(830_000, 1'b1);
        RST_N = 1'b1;

        // Interrupted acquire: release 920, 10th edge at 1110, reset at 1115.
        #380;
        RST_N = 1'b0;
        #20;
        RST_N = 1'b1;
        #195;
        check("acq_10_edges_unlocked", longint'(dut_if.SYS_CLK_LOCKED), 0);
        RST_N = 1'b0;
        #25;
        // Fresh release at 1140 ns: edges from 1150, 16th at 1450 ns.
        expect_lock(1_450_000, 1'b0);
        RST_N = 1'b1;
        #120;
        check("no_lock_after_6_fresh", longint'(dut_if.SYS_CLK_LOCKED), 0);
        #200;
        check("relocked_1460ns", longint'(dut_if.SYS_CLK_LOCKED), 1);

        #40;
        check("lock_queue_drained", lock_q.size(), 0);
        left = 0;
        for (int i = 0; i < 6; i++) left += per_q[i].size() + hi_q[i].size();
        check("clock_queues_drained", left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
